// File: rtl/alu_muldiv_seq_if.sv
// alu_muldiv_seq_if
//   Handshake and operand/result bundle for the alu_muldiv_seq execute unit.
//   master : pipeline side (presents operations, consumes results)
//   slave  : execute unit
//   Signals:
//     in_valid / in_ready      operation handshake
//     A, B, opcode, func3, func7  operands and instruction fields
//     out_valid / out_ready    result handshake
//     Y, carry_flag, overflow_flag, zero_flag, negative_flag, illegal_op  result
interface alu_muldiv_seq_if #(
   parameter int unsigned XLEN = 32
);
   logic            in_valid;
   logic            in_ready;
   logic [XLEN-1:0] A;
   logic [XLEN-1:0] B;
   logic [6:0]      opcode;
   logic [2:0]      func3;
   logic [6:0]      func7;
   logic            out_valid;
   logic            out_ready;
   logic [XLEN-1:0] Y;
   logic            carry_flag;
   logic            overflow_flag;
   logic            zero_flag;
   logic            negative_flag;
   logic            illegal_op;

   modport master (
      output in_valid, A, B, opcode, func3, func7, out_ready,
      input  in_ready, out_valid, Y, carry_flag, overflow_flag, zero_flag,
             negative_flag, illegal_op
   );

   modport slave (
      input  in_valid, A, B, opcode, func3, func7, out_ready,
      output in_ready, out_valid, Y, carry_flag, overflow_flag, zero_flag,
             negative_flag, illegal_op
   );
endinterface

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq
//   Handshaked RV32I/RV32M execute unit. Base ops register their result in
//   one cycle; MUL*/DIV*/REM* iterate one bit per cycle for XLEN cycles.
//   Ports:
//     clk   rising-edge clock
//     rst   synchronous active-high reset (aborts any mul/div in flight)
//     bus   alu_muldiv_seq_if.slave: in/out valid-ready handshake, A, B,
//           opcode, func3, func7, Y and flags, illegal_op
module alu_muldiv_seq #(
   parameter int unsigned XLEN = 32
) (
   input logic            clk,
   input logic            rst,
   alu_muldiv_seq_if.slave bus
);
   localparam int unsigned SHW    = $clog2(XLEN);
   localparam logic [6:0]  OP_R   = 7'b0110011;
   localparam logic [6:0]  OP_I   = 7'b0010011;
   localparam logic [6:0]  F7_STD = 7'b0000000;
   localparam logic [6:0]  F7_ALT = 7'b0100000;
   localparam logic [6:0]  F7_M   = 7'b0000001;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;
   state_t state, state_nx;

   logic [SHW-1:0] cnt;
   logic           accept, last;

   logic [XLEN-1:0] y_q;
   logic            c_q, v_q, z_q, n_q, ill_q;

   logic            is_r, is_i, is_m, alt, sub, dec_ill;
   logic            signed_a, signed_b, sa, sb;
   logic            div_zero, div_ovf, start_mul, start_div;
   logic [XLEN-1:0] b_add, mag_a, mag_b, base_y;
   logic [XLEN:0]   sum;
   logic            base_c, base_v;

   logic [2*XLEN-1:0] mc, prod, prod_nx, prod_f;
   logic [XLEN-1:0]   mp, dq, dq_nx, dv, rm, rm_nx, q_f, r_f;
   logic [XLEN:0]     rs, diff;
   logic              neg, sel_hi, q_neg, r_neg, sel_rem;

   logic            load, res_c, res_v, res_ill;
   logic [XLEN-1:0] res_y;

   assign accept        = bus.in_valid & bus.in_ready;
   assign last          = (cnt == SHW'(XLEN-1));
   assign bus.in_ready  = (state == S_IDLE) | ((state == S_DONE) & bus.out_ready);
   assign bus.out_valid = (state == S_DONE);
   assign bus.Y             = y_q;
   assign bus.carry_flag    = c_q;
   assign bus.overflow_flag = v_q;
   assign bus.zero_flag     = z_q;
   assign bus.negative_flag = n_q;
   assign bus.illegal_op    = ill_q;

   // Decode and single-cycle base datapath
   always_comb begin
      is_r    = (bus.opcode == OP_R);
      is_i    = (bus.opcode == OP_I);
      is_m    = is_r & (bus.func7 == F7_M);
      alt     = (bus.func7 == F7_ALT);
      sub     = is_r & alt & (bus.func3 == 3'b000);
      dec_ill = 1'b0;
      if (!(is_r || is_i))
         dec_ill = 1'b1;
      else if (is_r && !((bus.func7 == F7_STD) || is_m ||
                         (alt && (bus.func3 == 3'b000 || bus.func3 == 3'b101))))
         dec_ill = 1'b1;

      b_add  = sub ? ~bus.B : bus.B;
      sum    = {1'b0, bus.A} + {1'b0, b_add} + {{XLEN{1'b0}}, sub};
      base_y = '0;
      base_c = 1'b0;
      base_v = 1'b0;
      case (bus.func3)
         3'b000: begin
            base_y = sum[XLEN-1:0];
            base_c = sum[XLEN];
            base_v = (bus.A[XLEN-1] == b_add[XLEN-1]) & (sum[XLEN-1] != bus.A[XLEN-1]);
         end
         3'b001: base_y = bus.A << bus.B[SHW-1:0];
         3'b010: base_y = {{(XLEN-1){1'b0}}, ($signed(bus.A) < $signed(bus.B))};
         3'b011: base_y = {{(XLEN-1){1'b0}}, (bus.A < bus.B)};
         3'b100: base_y = bus.A ^ bus.B;
         3'b101: begin
            // Separate assignments keep >>> in a signed context
            if (alt) base_y = $signed(bus.A) >>> bus.B[SHW-1:0];
            else     base_y = bus.A >> bus.B[SHW-1:0];
         end
         3'b110: base_y = bus.A | bus.B;
         default: base_y = bus.A & bus.B;
      endcase

      // func3[2]: 0 = MUL family (00 ss, 01 ss, 10 su, 11 uu), 1 = DIV family (odd = unsigned)
      signed_a  = bus.func3[2] ? ~bus.func3[0] : (bus.func3[1:0] != 2'b11);
      signed_b  = bus.func3[2] ? ~bus.func3[0] : ~bus.func3[1];
      sa        = signed_a & bus.A[XLEN-1];
      sb        = signed_b & bus.B[XLEN-1];
      mag_a     = sa ? -bus.A : bus.A;
      mag_b     = sb ? -bus.B : bus.B;
      div_zero  = (bus.B == '0);
      div_ovf   = ~bus.func3[0] & (bus.A == {1'b1, {(XLEN-1){1'b0}}}) & (bus.B == '1);
      start_mul = is_m & ~bus.func3[2];
      start_div = is_m & bus.func3[2] & ~div_zero & ~div_ovf;
   end

   // One iteration of shift-add multiply and restoring divide
   always_comb begin
      prod_nx = prod + (mp[0] ? mc : '0);
      rs      = {rm, dq[XLEN-1]};
      diff    = rs - {1'b0, dv};
      if (diff[XLEN]) begin
         rm_nx = rs[XLEN-1:0];
         dq_nx = {dq[XLEN-2:0], 1'b0};
      end else begin
         rm_nx = diff[XLEN-1:0];
         dq_nx = {dq[XLEN-2:0], 1'b1};
      end
      prod_f = neg ? -prod_nx : prod_nx;
      q_f    = q_neg ? -dq_nx : dq_nx;
      r_f    = r_neg ? -rm_nx : rm_nx;
   end

   // Result register load select
   always_comb begin
      load    = 1'b0;
      res_y   = '0;
      res_c   = 1'b0;
      res_v   = 1'b0;
      res_ill = 1'b0;
      if (accept && !start_mul && !start_div) begin
         load = 1'b1;
         if (dec_ill)
            res_ill = 1'b1;
         else if (is_m) begin
            // Only the divide special cases reach here
            if (div_zero) res_y = bus.func3[1] ? bus.A : '1;
            else          res_y = bus.func3[1] ? '0 : bus.A;
         end else begin
            res_y = base_y;
            if (bus.func3 == 3'b000) begin
               res_c = base_c;
               res_v = base_v;
            end
         end
      end else if (state == S_MUL && last) begin
         load  = 1'b1;
         res_y = sel_hi ? prod_f[2*XLEN-1:XLEN] : prod_f[XLEN-1:0];
      end else if (state == S_DIV && last) begin
         load  = 1'b1;
         res_y = sel_rem ? r_f : q_f;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (start_mul)      state_nx = S_MUL;
               else if (start_div) state_nx = S_DIV;
               else                state_nx = S_DONE;
            end else if (state == S_DONE && bus.out_ready)
               state_nx = S_IDLE;
         end
         S_MUL, S_DIV: if (last) state_nx = S_DONE;
         default: state_nx = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nx;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         y_q   <= '0;
         c_q   <= 1'b0;
         v_q   <= 1'b0;
         z_q   <= 1'b0;
         n_q   <= 1'b0;
         ill_q <= 1'b0;
         cnt   <= '0;
      end else begin
         if (load) begin
            y_q   <= res_y;
            c_q   <= res_c;
            v_q   <= res_v;
            z_q   <= (res_y == '0);
            n_q   <= res_y[XLEN-1];
            ill_q <= res_ill;
         end
         if (accept && start_mul) begin
            mc     <= {{XLEN{1'b0}}, mag_a};
            mp     <= mag_b;
            prod   <= '0;
            neg    <= sa ^ sb;
            sel_hi <= (bus.func3[1:0] != 2'b00);
            cnt    <= '0;
         end
         if (accept && start_div) begin
            dq      <= mag_a;
            rm      <= '0;
            dv      <= mag_b;
            q_neg   <= sa ^ sb;
            r_neg   <= sa;
            sel_rem <= bus.func3[1];
            cnt     <= '0;
         end
         if (state == S_MUL) begin
            prod <= prod_nx;
            mc   <= mc << 1;
            mp   <= mp >> 1;
            cnt  <= cnt + SHW'(1);
         end
         if (state == S_DIV) begin
            rm  <= rm_nx;
            dq  <= dq_nx;
            cnt <= cnt + SHW'(1);
         end
      end
   end
endmodule
